// File: rtl/aon_clk_monitor_pkg.sv
// aon_clk_monitor_pkg: state encoding and default timing constants for the AON slow-clock monitor
package aon_clk_monitor_pkg;
  typedef enum logic [1:0] {IDLE, ACQUIRE, MEASURE, LOCKED} state_t;
  localparam int NOMINAL_PERIOD_DEF = 512;
  localparam int TOLERANCE_DEF = 4;
  localparam int TIMEOUT_DEF = 1024;
  // Written as v + tol >= nominal so a tolerance wider than nominal never goes negative
  function automatic logic in_window(int unsigned v, int unsigned nominal, int unsigned tol);
    return (v + tol >= nominal) && (v <= nominal + tol);
  endfunction
endpackage

// File: rtl/aon_clk_monitor_if.sv
// aon_clk_monitor_if: control/status bundle between the slow-clock monitor and its consumers
interface aon_clk_monitor_if #(parameter int CNT_W = 12);
  logic enable, slow_clk, clear_err, tick, period_valid, err_freq, err_stuck, locked;
  logic [CNT_W-1:0] period;
  modport master (output enable, slow_clk, clear_err,
                  input tick, period, period_valid, err_freq, err_stuck, locked);
  modport slave (input enable, slow_clk, clear_err,
                 output tick, period, period_valid, err_freq, err_stuck, locked);
endinterface

// File: rtl/aon_clk_monitor_sync_edge_detect.sv
// aon_clk_monitor_sync_edge_detect: multi-flop synchronizer with a registered rising-edge pulse
module aon_clk_monitor_sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic rise_o
);
  logic [STAGES-1:0] sync_q;
  logic hist_q, rise_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      hist_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~hist_q;
    end
  assign rise_o = rise_q;
endmodule

// File: rtl/aon_clk_monitor.sv
// aon_clk_monitor: measures the synchronized AON slow-clock period in fast cycles,
// flagging frequency/stuck errors and reporting lock after consecutive good periods
module aon_clk_monitor
  import aon_clk_monitor_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int CNT_W          = 12,
  parameter int NOMINAL_PERIOD = NOMINAL_PERIOD_DEF,
  parameter int TOLERANCE      = TOLERANCE_DEF,
  parameter int TIMEOUT        = TIMEOUT_DEF,
  parameter int LOCK_COUNT     = 4
) (
  input logic clk,
  input logic reset_n,
  aon_clk_monitor_if.slave bus
);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [GW-1:0] LOCK_N = GW'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, period_q, period_d;
  logic [GW-1:0] good_q, good_d, good_inc;
  logic pv_q, pv_d, ef_q, ef_d, es_q, es_d, rise, in_rng;
  aon_clk_monitor_sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .reset_n(reset_n), .d_i(bus.slow_clk), .rise_o(rise)
  );
  assign cnt_inc  = &cnt_q ? cnt_q : cnt_q + 1'b1;
  assign good_inc = good_q == LOCK_N ? good_q : good_q + 1'b1;
  assign in_rng   = in_window(32'(cnt_q), NOMINAL_PERIOD, TOLERANCE);
  // Priority: disable, then leaving IDLE, then an edge (which beats a same-cycle timeout), then timeout
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_inc;
    period_d = period_q;
    good_d   = good_q;
    pv_d     = 1'b0;
    ef_d     = ef_q & ~bus.clear_err;
    es_d     = es_q & ~bus.clear_err;
    if (!bus.enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      good_d  = '0;
    end else if (state_q == IDLE) begin
      state_d = ACQUIRE;
      cnt_d   = '0;
    end else if (rise) begin
      cnt_d = CNT_W'(1);
      if (state_q == ACQUIRE) begin
        state_d = MEASURE;
      end else begin
        period_d = cnt_q;
        pv_d     = 1'b1;
        good_d   = in_rng ? good_inc : '0;
        ef_d     = ef_d | ~in_rng;
        state_d  = in_rng && good_inc == LOCK_N ? LOCKED : MEASURE;
      end
    end else if (cnt_q >= TMO) begin
      state_d = ACQUIRE;
      cnt_d   = '0;
      good_d  = '0;
      es_d    = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      good_q   <= '0;
      pv_q     <= 1'b0;
      ef_q     <= 1'b0;
      es_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      good_q   <= good_d;
      pv_q     <= pv_d;
      ef_q     <= ef_d;
      es_q     <= es_d;
    end
  assign bus.tick         = rise && state_q != IDLE;
  assign bus.period       = period_q;
  assign bus.period_valid = pv_q;
  assign bus.err_freq     = ef_q;
  assign bus.err_stuck    = es_q;
  assign bus.locked       = state_q == LOCKED;
endmodule
